sseg_scan_display: RTL

- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Consumes the four BCD digits d3..d0 produced by the stopwatch stage, plus per-digit decimal-point requests.
- Scans one digit at a time with leading-zero blanking, an error glyph for non-BCD codes, and a freeze (lap-hold) snapshot.
- Sits between the stopwatch and the board anode/segment pins.

---
 rtl/sseg_scan_display.sv | 101 ++++++++++
 1 files changed

// File: rtl/sseg_scan_display.sv
// Time-multiplexed 4-digit 7-segment driver with leading-zero blanking,
// a dash glyph for non-BCD codes and a freeze (lap-hold) snapshot.
module sseg_scan_display #(
   parameter int unsigned REFRESH_BITS = 18,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic [3:0] dp_in,
   input  logic       blank_lz,
   input  logic       freeze,
   output logic [3:0] an,
   output logic [7:0] sseg
);

   logic [REFRESH_BITS-1:0] cnt;
   logic                    tick;
   logic [1:0]              sel;
   logic [3:0][3:0]         snap_d;
   logic [3:0]              snap_dp;

   logic [3:0]              occupied;
   logic [3:0]              blank;
   logic [3:0]              cur_digit;
   logic [3:0]              an_ah;
   logic [7:0]              sseg_ah;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
      logic [6:0] seg;
      seg = 7'h40;
      case (code)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h40;
      endcase
      return seg;
   endfunction

   assign tick = &cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         sel     <= '0;
         snap_d  <= '0;
         snap_dp <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (tick)
            sel <= sel + 2'd1;
         if (!freeze) begin
            snap_d  <= {d3, d2, d1, d0};
            snap_dp <= dp_in;
         end
      end
   end

   // Blanking propagates from the leftmost digit down; any nonzero digit or
   // lit dp breaks the chain for itself and everything to its right.
   always_comb begin
      for (int unsigned i = 0; i < 4; i++)
         occupied[i] = (snap_d[i] != 4'd0) || snap_dp[i];
      blank    = '0;
      blank[3] = blank_lz & ~occupied[3];
      blank[2] = blank[3] & ~occupied[2];
      blank[1] = blank[2] & ~occupied[1];
   end

   always_comb begin
      cur_digit = snap_d[sel];
      an_ah     = 4'b0001 << sel;
      sseg_ah   = {snap_dp[sel], bcd_to_seg(cur_digit)};
      if (blank[sel]) begin
         an_ah   = '0;
         sseg_ah = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an   <= ACTIVE_LOW ? '1 : '0;
         sseg <= ACTIVE_LOW ? '1 : '0;
      end else begin
         an   <= ACTIVE_LOW ? ~an_ah   : an_ah;
         sseg <= ACTIVE_LOW ? ~sseg_ah : sseg_ah;
      end
   end

endmodule
